pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits; legal range 1..1024.
REQ-002 Parameter CLEAR_ON_FLUSH, default 1: 1 = flush zeroes the data registers; 0 = flush clears only the valid flags.
REQ-003 Parameter CNT_W, default 16: stall counter width in bits; legal range 1..32.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset, sampled on the clk rising edge.
REQ-006 Port flush, input, 1: discard all held entries.
REQ-007 Port in_valid, input, 1: upstream payload valid.
REQ-008 Port in_data, input, WIDTH: upstream payload.
REQ-009 Port in_ready, output, 1: stage can accept in_data this cycle.
REQ-010 Port out_valid, output, 1: out_data is valid.
REQ-011 Port out_data, output, WIDTH: downstream payload.
REQ-012 Port out_ready, input, 1: downstream accepts this cycle.
REQ-013 Port occupancy, output, 2: number of held entries (0..2).
REQ-014 Port stall_cnt, output, CNT_W: saturating count of output-stall cycles.

Function
REQ-015 Storage: main register (main_q, main_v) and skid register (skid_q, skid_v) shall be the only payload storage.
REQ-016 out_data = main_q; out_valid = main_v; in_ready = !skid_v; occupancy = main_v + skid_v. All four are driven directly from registers, with no combinational in-to-out path.
REQ-017 An input fire (in_fire) shall occur when in_valid && in_ready. An output fire (out_fire) shall occur when out_valid && out_ready.
REQ-018 In state EMPTY (occupancy 0):
- in_fire: main_q <= in_data, next state ONE.
- otherwise: remain EMPTY.
REQ-019 In state ONE (occupancy 1, main_v only):
- in_fire && out_fire: main_q <= in_data, remain ONE.
- in_fire only: skid_q <= in_data, next state FULL.
- out_fire only: next state EMPTY.
- neither: hold.
REQ-020 In state FULL (in_ready = 0):
- out_fire: main_q <= skid_q, skid_v <= 0, next state ONE.
- otherwise: hold.
REQ-021 Ordering: payloads shall leave in exactly the order accepted, with no loss and no duplication. Latency from in_fire to out_valid shall be 1 cycle when the stage was EMPTY.
REQ-022 Throughput: with out_ready held at 1 and in_valid held at 1, the stage shall sustain one transfer per cycle and never enter FULL.
REQ-023 Flush takes priority over every handshake action. On a cycle with flush = 1:
- next state EMPTY.
- main_q and skid_q <= 0 if CLEAR_ON_FLUSH = 1, otherwise held.
- a coincident in_fire is discarded.
- a coincident out_fire counts as a completed transfer; the downstream side has already sampled it.
REQ-024 flush with occupancy 0 shall have no effect apart from the REQ-023 data clear.
REQ-025 stall_cnt shall increment by 1 on each cycle where out_valid && !out_ready, including flush cycles. It shall saturate at 2^CNT_W-1 with no wrap, and only rst clears it.
REQ-026 Payload bits shall pass through unmodified. X on in_data when in_valid = 0 shall not propagate to out_data while out_valid = 0 is being checked.

Reset
REQ-027 While rst = 1, on every clk edge:
- main_v, skid_v <= 0.
- main_q, skid_q <= 0.
- stall_cnt <= 0.
REQ-028 Output values after reset: out_valid = 0, out_data = 0, in_ready = 1, occupancy = 0, stall_cnt = 0.
REQ-029 rst shall override flush and all handshakes. Reset asserted mid-transfer shall drop every held entry.

Verification
REQ-030 Streaming, WIDTH = 32, out_ready = 1, inputs 0x11, 0x22, 0x33 on consecutive cycles -> out_data shows 0x11, 0x22, 0x33 one cycle later each; occupancy stays at most 1; stall_cnt = 0.
REQ-031 Backpressure: accept 0xA then 0xB with out_ready = 0 -> occupancy = 2, in_ready = 0, out_data = 0xA; stall_cnt increments by 1 per stalled cycle. Then raise out_ready -> 0xA then 0xB emerge, and in_ready returns to 1 the cycle after the first out_fire.
REQ-032 Flush while FULL with CLEAR_ON_FLUSH = 1, plus in_valid = 1 (0xC) in the same cycle -> next cycle occupancy = 0, out_data = 0, and 0xC never appears.
REQ-033 Flush with CLEAR_ON_FLUSH = 0 in state ONE holding 0x55 -> out_valid = 0 and out_data = 0x55 (held).
REQ-034 Saturation: CNT_W = 3 with out_valid = 1 and out_ready = 0 for 10 cycles -> stall_cnt reads 7 and holds at 7.
REQ-035 Reset mid-stream in state FULL -> next cycle all outputs equal the REQ-028 values, and the next accepted payload emerges first.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffer pipeline register with flush and a saturating
// output-stall counter. Every output is taken straight from a flop, so the
// stage breaks both the valid/data path and the ready path.
module pipe_skid_reg #(
  parameter int WIDTH          = 32,
  parameter int CLEAR_ON_FLUSH = 1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  // State codes double as the occupancy value, so occupancy is the state flop.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             main_v_q, skid_v_q;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             in_fire, out_fire;

  // Handshakes only look at registered flags, never at the opposite port.
  assign in_fire  = in_valid && !skid_v_q;
  assign out_fire = main_v_q && out_ready;

  assign in_ready  = !skid_v_q;
  assign out_valid = main_v_q;
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;

  // Next-state and payload steering; flush overrides every handshake action.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // An in_fire this cycle is dropped; an out_fire already completed downstream.
      state_d = ST_EMPTY;
      if (CLEAR_ON_FLUSH != 0) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            // Downstream stalled: park the new beat behind the head.
            skid_d  = in_data;
            state_d = ST_FULL;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: begin
          // Unreachable code: recover to a clean empty stage.
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Saturating count of cycles where a valid head is held by downstream.
  always_comb begin
    stall_d = stall_q;
    if (main_v_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // State, valid flags, payload and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      main_v_q <= (state_d != ST_EMPTY);
      skid_v_q <= (state_d == ST_FULL);
      main_q   <= main_d;
      skid_q   <= skid_d;
      stall_q  <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg. Three instances share one stimulus:
// the default build, a CLEAR_ON_FLUSH=0 build and a CNT_W=3 build.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_data;

  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  logic        nc_in_ready, nc_out_valid;
  logic [31:0] nc_out_data;
  logic [1:0]  nc_occupancy;
  logic [15:0] nc_stall_cnt;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_data;
  logic [1:0]  s_occupancy;
  logic [2:0]  s_stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(32), .CLEAR_ON_FLUSH(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .occupancy(occupancy), .stall_cnt(stall_cnt));

  pipe_skid_reg #(.WIDTH(32), .CLEAR_ON_FLUSH(0), .CNT_W(16)) dut_nc (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(nc_in_ready), .out_valid(nc_out_valid), .out_data(nc_out_data),
    .out_ready(out_ready), .occupancy(nc_occupancy), .stall_cnt(nc_stall_cnt));

  pipe_skid_reg #(.WIDTH(32), .CLEAR_ON_FLUSH(1), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data),
    .out_ready(out_ready), .occupancy(s_occupancy), .stall_cnt(s_stall_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    vectors++; if (out_data !== 32'h0) begin miscompares++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    vectors++; if (occupancy !== 2'd0) begin miscompares++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    vectors++; if (stall_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    logic [31:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = vals[i];
      tick();
      vectors++; if (out_valid !== 1'b1 || out_data !== vals[i]) begin miscompares++; $display("FAIL stream_beat%0d got=%b/%h exp=1/%h", i, out_valid, out_data, vals[i]); end
      vectors++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_occ%0d got=%0d/%b exp=1/1", i, occupancy, in_ready); end
      $display("stream beat %0d out=%h", i, out_data);
    end
    in_valid = 1'b0; in_data = 32'hx;
    tick();
    vectors++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin miscompares++; $display("FAIL stream_drain got=%b/%0d exp=0/0", out_valid, occupancy); end
    vectors++; if (stall_cnt !== 16'd0) begin miscompares++; $display("FAIL stream_stall got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    tick();
    vectors++; if (out_valid !== 1'b1 || out_data !== 32'hA || occupancy !== 2'd1 || stall_cnt !== 16'd0) begin miscompares++; $display("FAIL bp_first got=%b/%h/%0d/%0d exp=1/a/1/0", out_valid, out_data, occupancy, stall_cnt); end
    in_data = 32'hB;
    tick();
    vectors++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA) begin miscompares++; $display("FAIL bp_full got=%0d/%b/%h exp=2/0/a", occupancy, in_ready, out_data); end
    vectors++; if (stall_cnt !== 16'd1) begin miscompares++; $display("FAIL bp_stall1 got=%0d exp=1", stall_cnt); end
    in_valid = 1'b0; in_data = 32'hx;
    tick();
    vectors++; if (stall_cnt !== 16'd2 || occupancy !== 2'd2) begin miscompares++; $display("FAIL bp_stall2 got=%0d/%0d exp=2/2", stall_cnt, occupancy); end
    out_ready = 1'b1;
    tick();
    vectors++; if (out_data !== 32'hB || out_valid !== 1'b1 || in_ready !== 1'b1 || occupancy !== 2'd1) begin miscompares++; $display("FAIL bp_release got=%h/%b/%b/%0d exp=b/1/1/1", out_data, out_valid, in_ready, occupancy); end
    tick();
    vectors++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || stall_cnt !== 16'd2) begin miscompares++; $display("FAIL bp_empty got=%b/%0d/%0d exp=0/0/2", out_valid, occupancy, stall_cnt); end
    $display("test_backpressure done");
  endtask

  task automatic test_flush_full();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    flush = 1'b1; in_data = 32'hC;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    vectors++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_full got=%0d/%b/%h/%b exp=0/0/0/1", occupancy, out_valid, out_data, in_ready); end
    vectors++; if (stall_cnt !== 16'd2) begin miscompares++; $display("FAIL flush_stall got=%0d exp=2", stall_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_leak%0d got=%b/%h exp=0", i, out_valid, out_data); end
    end
    $display("test_flush_full done");
  endtask

  task automatic test_flush_noclear();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55;
    tick();
    vectors++; if (nc_out_valid !== 1'b1 || nc_out_data !== 32'h55) begin miscompares++; $display("FAIL noclear_load got=%b/%h exp=1/55", nc_out_valid, nc_out_data); end
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++; if (nc_out_valid !== 1'b0 || nc_out_data !== 32'h55 || nc_occupancy !== 2'd0) begin miscompares++; $display("FAIL noclear_hold got=%b/%h/%0d exp=0/55/0", nc_out_valid, nc_out_data, nc_occupancy); end
    vectors++; if (out_data !== 32'h0) begin miscompares++; $display("FAIL clear_zero got=%h exp=0", out_data); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++; if (occupancy !== 2'd0 || in_ready !== 1'b1 || stall_cnt !== 16'd1) begin miscompares++; $display("FAIL flush_empty got=%0d/%b/%0d exp=0/1/1", occupancy, in_ready, stall_cnt); end
    $display("test_flush_noclear done");
  endtask

  task automatic test_saturation();
    int exp_s;
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_s = (k > 7) ? 7 : k;
      vectors++; if (s_stall_cnt !== 3'(exp_s)) begin miscompares++; $display("FAIL sat_cnt%0d got=%0d exp=%0d", k, s_stall_cnt, exp_s); end
      vectors++; if (stall_cnt !== 16'(k)) begin miscompares++; $display("FAIL wide_cnt%0d got=%0d exp=%0d", k, stall_cnt, k); end
    end
    $display("test_saturation done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    rst = 1'b1; flush = 1'b1; in_data = 32'hE; out_ready = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
    vectors++; if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1 || occupancy !== 2'd0 || stall_cnt !== 16'd0) begin miscompares++; $display("FAIL rstmid_state got=%b/%h/%b/%0d/%0d exp=0/0/1/0/0", out_valid, out_data, in_ready, occupancy, stall_cnt); end
    in_valid = 1'b1; in_data = 32'hD;
    tick();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || out_data !== 32'hD) begin miscompares++; $display("FAIL rstmid_next got=%b/%h exp=1/d", out_valid, out_data); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_drain got=%b exp=0", out_valid); end
    $display("test_reset_mid done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [15:0] pat;
    logic [31:0] nxt;
    int          budget;
    pat = 16'b1011_0010_1110_0101;
    nxt = 32'h100;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      out_ready = pat[i % 16];
      in_valid  = (i % 5) != 3;
      in_data   = in_valid ? nxt : 32'hx;
      if (out_valid && out_ready) begin
        vectors++; if (q.size() == 0 || out_data !== q[0]) begin miscompares++; $display("FAIL b2b_order%0d got=%h exp=%h", i, out_data, (q.size() == 0) ? 32'hx : q[0]); end
        $display("b2b out %h", out_data);
        if (q.size() != 0) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        q.push_back(nxt);
        nxt = nxt + 32'h1;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    budget = 10;
    while (q.size() != 0 && budget > 0) begin
      if (out_valid) begin
        vectors++; if (out_data !== q[0]) begin miscompares++; $display("FAIL b2b_drain got=%h exp=%h", out_data, q[0]); end
        void'(q.pop_front());
      end
      tick();
      budget--;
    end
    vectors++; if (q.size() != 0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_leftover got=%0d/%b exp=0/0", q.size(), out_valid); end
    $display("test_back_to_back done");
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_flush_noclear();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
